// File: rtl/vga_trace_renderer.sv
// Pixel-colour stage behind the VGA sync generator.
// Two 640-entry sample banks: one is displayed while the capture side fills
// the other. The banks trade places only on a frame boundary so a frame never
// mixes old and new samples. A three-stage pipeline turns the generator's
// pixel counters into registered 1-bit RGB: graticule plus a connected trace.
// The syncs travel through the same three stages so they stay aligned.
module vga_trace_renderer #(
    parameter int SAMPLE_BITS = 8,
    parameter int Y_OFFSET    = 112
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [9:0]             counter_x,
    input  logic [8:0]             counter_y,
    input  logic                   in_display,
    input  logic                   hsync_in,
    input  logic                   vsync_in,
    input  logic                   wr_en,
    input  logic [9:0]             wr_addr,
    input  logic [SAMPLE_BITS-1:0] wr_data,
    input  logic                   wr_done,
    output logic                   swap_ack,
    output logic [7:0]             frame_count,
    output logic                   vga_r,
    output logic                   vga_g,
    output logic                   vga_b,
    output logic                   hsync_out,
    output logic                   vsync_out
);

    localparam int NUM_COLS = 640;

    // Sample banks; bankSel names the bank currently on screen.
    logic [SAMPLE_BITS-1:0] bank0 [0:NUM_COLS-1];
    logic [SAMPLE_BITS-1:0] bank1 [0:NUM_COLS-1];
    logic [SAMPLE_BITS-1:0] bank0Q, bank1Q;

    logic       bankSel, swapPending, traceValid;
    logic       wrOk, frameEdge, doSwap;
    logic [9:0] rdAddr;

    // Stage 1 registers
    logic [9:0] s1X;
    logic [8:0] s1Y;
    logic       s1Disp, s1Hs, s1Vs, readSel;

    // Stage 2 registers
    logic [9:0] s2X;
    logic [8:0] s2Y;
    logic       s2Disp, s2Hs, s2Vs;
    logic [8:0] s2Row, prevRow;

    logic [7:0] sampleTop;
    logic [8:0] rowNext, rowLo, rowHi;
    logic [7:0] gridRowHit;
    logic       traceHit, gridHit;
    logic [2:0] colourNext;

    // Out-of-range columns are dropped rather than aliased onto real ones.
    assign wrOk   = wr_en && (wr_addr < 10'd640);
    // Blanking columns read the last visible sample; in_display masks them.
    assign rdAddr = (counter_x > 10'd639) ? 10'd639 : counter_x;

    // s1Y holds last clock's row, so this fires once on entry to row 480.
    assign frameEdge = (counter_y == 9'd480) && (s1Y != 9'd480);
    // A completion strobe arriving in the boundary clock itself still swaps.
    assign doSwap    = frameEdge && (swapPending || wr_done);

    // Bank storage: writes go to the hidden bank, both banks read every clock.
    always_ff @(posedge clk) begin
        if (wrOk && bankSel)
            bank0[wr_addr] <= wr_data;
        if (wrOk && !bankSel)
            bank1[wr_addr] <= wr_data;
        bank0Q <= bank0[rdAddr];
        bank1Q <= bank1[rdAddr];
    end

    // Swap bookkeeping and frame counter, all keyed to the frame boundary.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bankSel     <= 1'b0;
            swapPending <= 1'b0;
            traceValid  <= 1'b0;
            swap_ack    <= 1'b0;
            frame_count <= 8'd0;
        end else begin
            swap_ack <= doSwap;
            if (frameEdge)
                frame_count <= frame_count + 8'd1;
            if (doSwap) begin
                bankSel     <= ~bankSel;
                swapPending <= 1'b0;
                traceValid  <= 1'b1;
            end else if (wr_done) begin
                swapPending <= 1'b1;
            end
        end
    end

    // Stage 1: capture generator outputs alongside the RAM read.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1X     <= 10'd0;
            s1Y     <= 9'd0;
            s1Disp  <= 1'b0;
            s1Hs    <= 1'b1;
            s1Vs    <= 1'b1;
            readSel <= 1'b0;
        end else begin
            s1X     <= counter_x;
            s1Y     <= counter_y;
            s1Disp  <= in_display;
            s1Hs    <= hsync_in;
            s1Vs    <= vsync_in;
            readSel <= bankSel;
        end
    end

    // The bank that was on screen when the read was issued supplies the sample.
    assign sampleTop = readSel ? bank1Q[SAMPLE_BITS-1 -: 8] : bank0Q[SAMPLE_BITS-1 -: 8];
    assign rowNext   = 9'(Y_OFFSET + 255) - {1'b0, sampleTop};

    // Stage 2: sample to screen row; remember the previous column's row.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s2X     <= 10'd0;
            s2Y     <= 9'd0;
            s2Disp  <= 1'b0;
            s2Hs    <= 1'b1;
            s2Vs    <= 1'b1;
            s2Row   <= 9'd0;
            prevRow <= 9'd0;
        end else begin
            s2X    <= s1X;
            s2Y    <= s1Y;
            s2Disp <= s1Disp;
            s2Hs   <= s1Hs;
            s2Vs   <= s1Vs;
            s2Row  <= rowNext;
            // Each column is shown for two clocks; only a new column retires the row.
            if (s1X != s2X)
                prevRow <= s2Row;
        end
    end

    // Vertical run between neighbouring samples keeps the trace connected.
    assign rowLo    = (s2Row < prevRow) ? s2Row : prevRow;
    assign rowHi    = (s2Row < prevRow) ? prevRow : s2Row;
    assign traceHit = (s2X == 10'd0) ? (s2Y == s2Row) : ((s2Y >= rowLo) && (s2Y <= rowHi));

    // Horizontal graticule lines every 60 rows from 0 to 420.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : genGridRow
            assign gridRowHit[gi] = (s2Y == 9'(gi * 60));
        end
    endgenerate

    assign gridHit = (s2X[5:0] == 6'd0) || (s2X == 10'd639) || (|gridRowHit) || (s2Y == 9'd479);

    // Colour priority: trace over grid, everything black outside the display.
    always_comb begin
        colourNext = 3'b000;
        if (s2Disp) begin
            if (traceValid && traceHit)
                colourNext = 3'b010;
            else if (gridHit)
                colourNext = 3'b001;
        end
    end

    // Stage 3: registered colour and delayed syncs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vga_r     <= 1'b0;
            vga_g     <= 1'b0;
            vga_b     <= 1'b0;
            hsync_out <= 1'b1;
            vsync_out <= 1'b1;
        end else begin
            vga_r     <= colourNext[2];
            vga_g     <= colourNext[1];
            vga_b     <= colourNext[0];
            hsync_out <= s2Hs;
            vsync_out <= s2Vs;
        end
    end

endmodule

// File: tb/tb_vga_trace_renderer.sv
// Bench for vga_trace_renderer: table of grid vectors, hand-written swap and
// reset sequences, and randomized sample sweeps scored against a pixel model.
module tb_vga_trace_renderer;

    logic       clk = 1'b0;
    logic       rstn;
    logic [9:0] counter_x;
    logic [8:0] counter_y;
    logic       in_display, hsync_in, vsync_in;
    logic       wr_en;
    logic [9:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_done;
    logic       swap_ack;
    logic [7:0] frame_count;
    logic       vga_r, vga_g, vga_b, hsync_out, vsync_out;

    always #5 clk = ~clk;

    vga_trace_renderer #(.SAMPLE_BITS(8), .Y_OFFSET(112)) dut (
        .clk(clk), .rstn(rstn),
        .counter_x(counter_x), .counter_y(counter_y), .in_display(in_display),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_done(wr_done),
        .swap_ack(swap_ack), .frame_count(frame_count),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .hsync_out(hsync_out), .vsync_out(vsync_out)
    );

    int checks = 0;
    int errors = 0;

    // Reference state: physical bank contents and display bookkeeping.
    int memM [2][640];
    int frontM, pendM, tvM, fcM, lastY, curX, prevX, ackCount;

    typedef struct {
        bit         doCol;
        logic [2:0] rgb;
        logic       hs;
        logic       vs;
    } exp_t;
    exp_t expQ[$];

    typedef struct {
        int         x;
        int         y;
        bit         disp;
        logic [2:0] rgb;
    } vec_t;
    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
        end
    endtask

    function automatic int rowOf(int bank, int x);
        return 367 - memM[bank][x];
    endfunction

    function automatic logic [2:0] refColour(int x, int y, bit disp);
        int r, p, lo, hi;
        bit hit;
        if (!disp) return 3'b000;
        if (tvM != 0) begin
            r = rowOf(frontM, x);
            if (x == 0) begin
                hit = (y == r);
            end else begin
                p   = rowOf(frontM, x - 1);
                lo  = (r < p) ? r : p;
                hi  = (r < p) ? p : r;
                hit = (y >= lo) && (y <= hi);
            end
            if (hit) return 3'b010;
        end
        if ((x % 64 == 0) || (x == 639) || ((y % 60 == 0) && (y <= 420)) || (y == 479))
            return 3'b001;
        return 3'b000;
    endfunction

    task automatic resetModel();
        frontM = 0; pendM = 0; tvM = 0; fcM = 0; lastY = 0;
        curX = -1; prevX = -1;
        expQ.delete();
    endtask

    // One clock: predict, advance, update model, score.
    task automatic tick();
        exp_t e;
        bit   edgeM;
        int   cx, ackExp;
        hsync_in = 1'($urandom_range(0, 1));
        vsync_in = 1'($urandom_range(0, 1));
        cx = int'(counter_x);
        if (cx != curX) begin
            prevX = curX;
            curX  = cx;
        end
        e.doCol = !((tvM != 0) && in_display && (cx != 0) && (prevX != cx - 1));
        e.rgb   = refColour(cx, int'(counter_y), in_display);
        e.hs    = hsync_in;
        e.vs    = vsync_in;
        expQ.push_back(e);
        edgeM = (counter_y == 9'd480) && (lastY != 480);
        @(posedge clk);
        #1;
        lastY = int'(counter_y);
        if (wr_en && (wr_addr < 10'd640))
            memM[1 - frontM][wr_addr] = int'(wr_data);
        ackExp = 0;
        if (edgeM) begin
            fcM = (fcM + 1) % 256;
            if ((pendM != 0) || wr_done) begin
                frontM = 1 - frontM;
                pendM  = 0;
                tvM    = 1;
                ackExp = 1;
            end
        end else if (wr_done) begin
            pendM = 1;
        end
        check("swap_ack", 32'(swap_ack), 32'(ackExp));
        check("frame_count", 32'(frame_count), 32'(fcM));
        if (swap_ack) ackCount++;
        if (expQ.size() == 3) begin
            e = expQ.pop_front();
            if (e.doCol) check("colour", 32'({vga_r, vga_g, vga_b}), 32'(e.rgb));
            check("hsync_out", 32'(hsync_out), 32'(e.hs));
            check("vsync_out", 32'(vsync_out), 32'(e.vs));
        end
    endtask

    task automatic setPix(int x, int y, bit disp);
        counter_x  = 10'(x);
        counter_y  = 9'(y);
        in_display = disp;
    endtask

    task automatic idle(int n);
        setPix(700, 490, 0);
        wr_en = 0; wr_done = 0;
        repeat (n) tick();
    endtask

    task automatic sweepRow(int y, int x0, int x1);
        for (int x = x0; x <= x1; x++) begin
            setPix(x, y, x <= 639);
            tick();
            tick();
        end
    endtask

    task automatic writeSample(int a, int d);
        wr_en = 1; wr_addr = 10'(a); wr_data = 8'(d);
        tick();
        wr_en = 0;
    endtask

    task automatic pulseDone();
        setPix(700, 200, 0);
        wr_done = 1;
        tick();
        wr_done = 0;
    endtask

    task automatic boundary(bit withDone, bit withWrite, int a, int d);
        setPix(700, 479, 0);
        tick();
        setPix(700, 480, 0);
        wr_done = withDone; wr_en = withWrite; wr_addr = 10'(a); wr_data = 8'(d);
        tick();
        wr_done = 0; wr_en = 0;
        tick();
        setPix(700, 490, 0);
        tick();
    endtask

    task automatic checkResetOutputs(string tag);
        check({tag, "_rgb"}, 32'({vga_r, vga_g, vga_b}), 32'd0);
        check({tag, "_hsync"}, 32'(hsync_out), 32'd1);
        check({tag, "_vsync"}, 32'(vsync_out), 32'd1);
        check({tag, "_swap_ack"}, 32'(swap_ack), 32'd0);
        check({tag, "_frame_count"}, 32'(frame_count), 32'd0);
    endtask

    initial begin
        int ackBefore;

        vecs[0]  = '{0,   5,   1'b1, 3'b001};
        vecs[1]  = '{64,  5,   1'b1, 3'b001};
        vecs[2]  = '{639, 5,   1'b1, 3'b001};
        vecs[3]  = '{65,  5,   1'b1, 3'b000};
        vecs[4]  = '{5,   0,   1'b1, 3'b001};
        vecs[5]  = '{5,   60,  1'b1, 3'b001};
        vecs[6]  = '{5,   420, 1'b1, 3'b001};
        vecs[7]  = '{5,   479, 1'b1, 3'b001};
        vecs[8]  = '{5,   59,  1'b1, 3'b000};
        vecs[9]  = '{100, 100, 1'b0, 3'b000};
        vecs[10] = '{700, 0,   1'b0, 3'b000};
        vecs[11] = '{128, 200, 1'b1, 3'b001};
        vecs[12] = '{1,   1,   1'b1, 3'b000};
        vecs[13] = '{638, 478, 1'b1, 3'b000};

        for (int b = 0; b < 2; b++)
            for (int a = 0; a < 640; a++)
                memM[b][a] = 0;
        ackCount = 0;
        rstn = 1; wr_en = 0; wr_addr = 0; wr_data = 0; wr_done = 0;
        hsync_in = 1; vsync_in = 1;
        setPix(700, 490, 0);

        // Power-on reset
        #2 rstn = 0;
        #1 checkResetOutputs("reset");
        repeat (2) @(posedge clk);
        @(negedge clk) rstn = 1;
        resetModel();

        // Grid-only vectors before any swap
        for (int i = 0; i < 14; i++) begin
            setPix(vecs[i].x, vecs[i].y, vecs[i].disp);
            tick(); tick(); tick();
            check($sformatf("grid_vec%0d", i), 32'({vga_r, vga_g, vga_b}), 32'(vecs[i].rgb));
        end

        boundary(0, 0, 0, 0);
        check("frame_count_first_boundary", 32'(frame_count), 32'd1);

        // Flat 128 in back bank, repeated completion strobes, one swap
        idle(2);
        for (int a = 0; a < 640; a++) writeSample(a, 128);
        ackBefore = ackCount;
        pulseDone();
        idle(3);
        pulseDone();
        boundary(0, 0, 0, 0);
        idle(3);
        check("single_swap_ack", 32'(ackCount - ackBefore), 32'd1);
        for (int y = 238; y <= 240; y++) sweepRow(y, 0, 639);
        sweepRow(239, 63, 64);
        tick();
        check("trace_over_grid_x64", 32'({vga_r, vga_g, vga_b}), 32'b010);

        // Ramp with a full-scale step at column 300
        idle(2);
        for (int a = 0; a < 640; a++)
            writeSample(a, (a == 299) ? 0 : (a == 300) ? 255 : (a % 256));
        pulseDone();
        boundary(0, 0, 0, 0);
        for (int y = 100; y <= 380; y++) sweepRow(y, 299, 301);
        begin
            int ys[5];
            logic [2:0] want[5];
            ys = '{111, 112, 240, 367, 368};
            want = '{3'b000, 3'b010, 3'b010, 3'b010, 3'b000};
            for (int i = 0; i < 5; i++) begin
                sweepRow(ys[i], 299, 300);
                tick();
                check($sformatf("step_col300_y%0d", ys[i]), 32'({vga_r, vga_g, vga_b}), 32'(want[i]));
            end
        end

        // Completion strobe and a write both in the boundary clock
        idle(2);
        ackBefore = ackCount;
        boundary(1, 1, 5, 20);
        check("boundary_clock_swap", 32'(ackCount - ackBefore), 32'd1);
        for (int y = 236; y <= 242; y++) sweepRow(y, 0, 8);
        for (int y = 340; y <= 350; y++) sweepRow(y, 0, 8);
        sweepRow(347, 4, 5);
        tick();
        check("boundary_write_addr5", 32'({vga_r, vga_g, vga_b}), 32'b010);

        // Randomized sample sets, with ignored out-of-range writes mixed in
        for (int it = 0; it < 3; it++) begin
            idle(2);
            for (int a = 0; a < 640; a++) writeSample(a, int'($urandom_range(0, 255)));
            writeSample(700, int'($urandom_range(0, 255)));
            writeSample(int'($urandom_range(640, 1023)), int'($urandom_range(0, 255)));
            pulseDone();
            boundary(0, 0, 0, 0);
            for (int r = 0; r < 3; r++) sweepRow(int'($urandom_range(112, 367)), 0, 639);
            sweepRow(int'($urandom_range(0, 479)), 0, 639);
        end

        // Mid-line reset with a swap pending: pending is lost, grid only after
        pulseDone();
        setPix(50, 239, 1);
        tick();
        #2 rstn = 0;
        #1 checkResetOutputs("midline_reset");
        @(posedge clk);
        @(negedge clk) rstn = 1;
        resetModel();
        ackBefore = ackCount;
        boundary(0, 0, 0, 0);
        check("pending_lost_by_reset", 32'(ackCount - ackBefore), 32'd0);
        sweepRow(239, 0, 639);
        sweepRow(239, 1, 1);
        tick();
        check("grid_only_after_reset", 32'({vga_r, vga_g, vga_b}), 32'b000);

        idle(4);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
